// File: rtl/pdl_pkg.sv
// Shared types and defaults for the programmable pulse delay line.
package pdl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } pdl_state_e;

  localparam int PDL_CW_DEFAULT = 32;

endpackage

// File: rtl/pdl_if.sv
// Trigger/config/strobe bundle between the trigger source and the delay line.
interface pdl_if
  import pdl_pkg::*;
#(
  parameter int CW = PDL_CW_DEFAULT
) ();

  logic          trigger;
  logic [CW-1:0] dl;
  logic [CW-1:0] wb;
  logic          delay_out;

  modport master (output trigger, output dl, output wb, input delay_out);
  modport slave  (input trigger, input dl, input wb, output delay_out);

endinterface

// File: rtl/pdl_edge_det.sv
// Synchronous rising-edge detector; the history flop follows the input even
// during reset so a level held across reset release is not seen as an edge.
module pdl_edge_det
  import pdl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_q;
  logic din_d;

  always_comb begin
    din_d = din;
  end

  always_ff @(posedge clk) begin
    din_q <= din_d;
  end

  assign rise = din & ~din_q & ~reset;

endmodule

// File: rtl/pdl.sv
// Programmable pulse delay line: after an accepted trigger edge, waits dl
// cycles and then drives delay_out high for wb cycles.
module pdl
  import pdl_pkg::*;
#(
  parameter int CW = PDL_CW_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  pdl_if.slave   bus
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  pdl_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wb_l_q, wb_l_d;
  logic          delay_out_q, delay_out_d;
  logic          trig_rise;

  pdl_edge_det u_edge_det (
    .clk   (clk),
    .reset (reset),
    .din   (bus.trigger),
    .rise  (trig_rise)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wb_l_d      = wb_l_q;
    delay_out_d = delay_out_q;
    unique case (state_q)
      IDLE: begin
        if (trig_rise) begin
          wb_l_d = bus.wb;
          // A zero width consumes the event without producing a pulse.
          if (bus.wb != '0) begin
            state_d = DELAY;
            cnt_d   = bus.dl;
          end
        end
      end
      DELAY: begin
        if (cnt_q == '0) begin
          delay_out_d = 1'b1;
          cnt_d       = wb_l_q - CNT_ONE;
          state_d     = PULSE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          delay_out_d = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d     = IDLE;
        delay_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wb_l_q      <= '0;
      delay_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_l_q      <= wb_l_d;
      delay_out_q <= delay_out_d;
    end
  end

  assign bus.delay_out = delay_out_q;

endmodule

// File: tb/tb_pdl.sv
// Directed bench for pdl: per-cycle vector table plus hand-written long sequences.
module tb_pdl;
  import pdl_pkg::*;

  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset;

  pdl_if #(.CW(CW)) bus ();

  pdl #(.CW(CW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          trig;
    logic [CW-1:0] dl;
    logic [CW-1:0] wb;
    logic          rst;
    logic          exp_out;
    string         name;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic trig, input logic [CW-1:0] dl, input logic [CW-1:0] wb,
                     input logic rst, input logic exp_out, input int n, input string name);
    vec_t v;
    v.trig = trig; v.dl = dl; v.wb = wb; v.rst = rst; v.exp_out = exp_out; v.name = name;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Inputs change at the falling edge, get sampled at the next rising edge,
  // and the registered output is checked at the following falling edge.
  task automatic step(input logic trig, input logic [CW-1:0] dl, input logic [CW-1:0] wb,
                      input logic rst, input logic exp_out, input string name);
    bus.trigger = trig;
    bus.dl      = dl;
    bus.wb      = wb;
    reset       = rst;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.delay_out !== exp_out) begin
      n_err++;
      $display("FAIL %s @%0t: delay_out=%b expected %b", name, $time, bus.delay_out, exp_out);
    end
  endtask

  initial begin
    bus.trigger = 1'b0;
    bus.dl      = '0;
    bus.wb      = '0;
    reset       = 1'b1;

    // basic dl=8 wb=5: high N+9..N+13
    add(0, 8, 5, 1, 0, 2, "reset");
    add(0, 8, 5, 0, 0, 2, "idle");
    add(1, 8, 5, 0, 0, 1, "b_edge");
    add(0, 8, 5, 0, 0, 8, "b_delay");
    add(0, 8, 5, 0, 1, 5, "b_pulse");
    add(0, 8, 5, 0, 0, 2, "b_after");
    // dl=0 wb=1: one-cycle pulse at N+1
    add(1, 0, 1, 0, 0, 1, "z_edge");
    add(0, 0, 1, 0, 1, 1, "z_pulse");
    add(0, 0, 1, 0, 0, 3, "z_after");
    // retrigger attempts and config change mid-flight are ignored
    add(1, 8, 5, 0, 0, 1, "r_edge");
    add(0, 8, 5, 0, 0, 1, "r_n1");
    add(0, 2, 2, 0, 0, 1, "r_cfg");
    add(1, 2, 2, 0, 0, 1, "r_retrig_delay");
    add(0, 2, 2, 0, 0, 5, "r_delay");
    add(0, 2, 2, 0, 1, 1, "r_pulse_a");
    add(1, 2, 2, 0, 1, 1, "r_retrig_pulse");
    add(0, 2, 2, 0, 1, 3, "r_pulse_b");
    add(0, 2, 2, 0, 0, 3, "r_after");
    // wb=0 event is swallowed; next edge with wb=3 pulses normally
    add(1, 4, 0, 0, 0, 1, "w0_edge");
    add(0, 4, 0, 0, 0, 8, "w0_quiet");
    add(1, 4, 3, 0, 0, 1, "w3_edge");
    add(0, 4, 3, 0, 0, 4, "w3_delay");
    add(0, 4, 3, 0, 1, 3, "w3_pulse");
    add(0, 4, 3, 0, 0, 2, "w3_after");
    // reset at N+10 aborts; trigger high across release does not fire
    add(1, 8, 5, 0, 0, 1, "x_edge");
    add(0, 8, 5, 0, 0, 8, "x_delay");
    add(0, 8, 5, 0, 1, 1, "x_pulse");
    add(1, 8, 5, 1, 0, 1, "x_reset");
    add(1, 8, 5, 0, 0, 12, "x_held");
    add(0, 8, 5, 0, 0, 1, "x_low");
    add(1, 8, 5, 0, 0, 1, "x2_edge");
    add(0, 8, 5, 0, 0, 8, "x2_delay");
    add(0, 8, 5, 0, 1, 5, "x2_pulse");
    add(0, 8, 5, 0, 0, 2, "x2_after");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].trig, vecs[i].dl, vecs[i].wb, vecs[i].rst, vecs[i].exp_out,
           $sformatf("%s[%0d]", vecs[i].name, i));

    // trigger held 40 cycles with dl=3 wb=4: one pulse at N+4..N+7
    for (int k = 0; k < 40; k++)
      step(1, 3, 4, 0, (k >= 4 && k <= 7), "hold");
    step(0, 3, 4, 0, 0, "hold_low");
    for (int k = 0; k < 10; k++)
      step(k == 0, 3, 4, 0, (k >= 4 && k <= 7), "hold_again");

    // maximum delay must not wrap early
    step(1, 32'hFFFF_FFFF, 2, 0, 0, "maxdl_edge");
    for (int k = 0; k < 150; k++)
      step(0, 32'hFFFF_FFFF, 2, 0, 0, "maxdl_wait");
    step(0, 0, 0, 1, 0, "maxdl_reset");
    step(0, 0, 0, 0, 0, "maxdl_release");

    // maximum width: high from N+2 onward until reset
    step(1, 1, 32'hFFFF_FFFF, 0, 0, "maxwb_edge");
    for (int k = 1; k <= 100; k++)
      step(0, 1, 32'hFFFF_FFFF, 0, (k >= 2), "maxwb_run");
    step(0, 1, 32'hFFFF_FFFF, 1, 0, "maxwb_reset");
    for (int k = 0; k < 3; k++)
      step(0, 1, 32'hFFFF_FFFF, 0, 0, "maxwb_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
